// File: rtl/axis_sample_packer.sv
// Packs 8-bit samples into 128-bit AXI4-Stream beats of 16 samples, frames them
// into packets with tlast, and buffers beats in a small FIFO for the master port.
module axis_sample_packer #(
  parameter int PKT_BEATS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          flush,
  output logic [127:0]                  m_axis_tdata,
  output logic [15:0]                   m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam int              ENT_W     = 1 + 16 + 128;
  localparam logic [15:0]     LAST_BEAT = 16'(PKT_BEATS - 1);
  localparam logic [PTR_W:0]  FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [3:0]        r_idx;
  logic [7:0]        r_hold [0:14];
  logic [15:0]       r_bcnt;
  logic [ENT_W-1:0]  r_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_level;
  logic              r_ovf;

  logic [4:0]        w_cnt;
  logic              w_full;
  logic              w_push;
  logic              w_last;
  logic [127:0]      w_data;
  logic [15:0]       w_keep;
  logic              w_pop;
  logic              w_wr;
  logic [ENT_W-1:0]  w_head;

  // w_cnt counts the samples in the beat including a same-cycle sample.
  assign w_cnt  = {1'b0, r_idx} + {4'b0000, in_valid};
  assign w_full = in_valid && (r_idx == 4'd15);
  assign w_push = w_full || (flush && (w_cnt != 5'd0));
  assign w_last = flush || (r_bcnt == LAST_BEAT);
  assign w_pop  = (r_level != '0) && m_axis_tready;
  assign w_wr   = w_push && ((r_level != FULL_LVL) || w_pop);

  // Stale holding bytes above the index are masked so partial beats pad with zeros.
  always_comb begin
    w_data = '0;
    w_keep = '0;
    for (int k = 0; k < 15; k++) begin
      if (4'(k) < r_idx) w_data[8*k +: 8] = r_hold[k];
    end
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < w_cnt) w_keep[k] = 1'b1;
      if (in_valid && (r_idx == 4'(k))) w_data[8*k +: 8] = in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx  <= '0;
      r_bcnt <= '0;
      for (int k = 0; k < 15; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < 15; k++) begin
        if (in_valid && (r_idx == 4'(k))) r_hold[k] <= in_data;
      end
      if (w_push) begin
        r_idx  <= '0;
        r_bcnt <= w_last ? '0 : r_bcnt + 16'd1;
      end else if (in_valid) begin
        r_idx  <= r_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)           r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)          r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_wr) r_ovf <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
        2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= {w_last, w_keep, w_data};
  end

  // Outputs are forced to zero while empty so reset clears them without clearing storage.
  assign w_head        = r_mem[r_rptr];
  assign m_axis_tvalid = (r_level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[127:0]   : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? w_head[143:128] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? w_head[144]     : 1'b0;
  assign overflow      = r_ovf;
  assign fifo_level    = r_level;

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed scoreboard bench for axis_sample_packer (PKT_BEATS=4, FIFO_DEPTH=4).
module tb_axis_sample_packer;

  localparam int PKT_BEATS  = 4;
  localparam int FIFO_DEPTH = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         flush = 1'b0;
  logic         m_axis_tready = 1'b0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         overflow;
  logic [2:0]   fifo_level;

  axis_sample_packer #(.PKT_BEATS(PKT_BEATS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [144:0] exp_q [$];
  logic [144:0] mon_e;
  int           m_idx, m_bcnt, m_level;
  logic         m_ovf;
  logic [7:0]   m_hold [16];

  task automatic chk(input string tag, input logic [144:0] obs, input logic [144:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_bcnt = 0; m_level = 0; m_ovf = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) m_hold[k] = 8'h00;
  endtask

  // Drive one cycle of input, update the reference model, then check after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic f);
    logic [144:0] beat, prev;
    logic push, pop, ok, stall;
    int cnt;
    in_valid = v; in_data = d; flush = f;
    stall = m_axis_tvalid && !m_axis_tready;
    prev  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    cnt   = m_idx + int'(v);
    push  = (v && m_idx == 15) || (f && cnt > 0);
    beat  = '0;
    if (v) m_hold[m_idx] = d;
    if (push) begin
      for (int k = 0; k < cnt; k++) begin
        beat[8*k +: 8] = m_hold[k];
        beat[128+k]    = 1'b1;
      end
      beat[144] = f || (m_bcnt == PKT_BEATS - 1);
      m_bcnt = beat[144] ? 0 : m_bcnt + 1;
      m_idx  = 0;
    end else if (v) begin
      m_idx++;
    end
    pop = (m_level > 0) && m_axis_tready;
    ok  = push && ((m_level < FIFO_DEPTH) || pop);
    if (push && !ok) m_ovf = 1'b1;
    if (ok) exp_q.push_back(beat);
    m_level = m_level + int'(ok) - int'(pop);
    @(posedge CLK); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("fifo_level", 145'(fifo_level), 145'(m_level));
    chk("tvalid", 145'(m_axis_tvalid), 145'(m_level != 0));
    chk("overflow", 145'(overflow), 145'(m_ovf));
    if (stall) chk("stall_head", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prev);
  endtask

  task automatic samples(input int n, input int base);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'(base + i), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("rst_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 145'(0));
    chk("rst_ctrl", 145'({m_axis_tvalid, overflow, fifo_level}), 145'(0));
    model_clear();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST && m_axis_tvalid && m_axis_tready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed %h expected no beat", m_axis_tdata);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    chk("init_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 145'(0));
    chk("init_ctrl", 145'({m_axis_tvalid, overflow, fifo_level}), 145'(0));
    RST = 1'b0;

    // Basic beat 0x00..0x0F
    m_axis_tready = 1'b1;
    samples(16, 8'h00);
    chk("t1_tdata", 145'(m_axis_tdata), 145'(128'h0F0E0D0C0B0A09080706050403020100));
    chk("t1_tkeep", 145'(m_axis_tkeep), 145'(16'hFFFF));
    chk("t1_tlast", 145'(m_axis_tlast), 145'(0));
    idle(2);

    // Packet framing: 4 beats then a fresh packet
    do_reset();
    samples(64, 8'h40);
    samples(16, 8'hC0);
    idle(2);

    // Flush of a partial beat, then a flush coinciding with the 16th sample
    samples(5, 8'hA1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t3_tdata", 145'(m_axis_tdata), 145'({88'h0, 40'hA5A4A3A2A1}));
    chk("t3_tkeep", 145'(m_axis_tkeep), 145'(16'h001F));
    chk("t3_tlast", 145'(m_axis_tlast), 145'(1));
    samples(16, 8'h50);
    samples(15, 8'h60);
    cycle(1'b1, 8'h6F, 1'b1);
    samples(16, 8'h70);
    idle(2);
    cycle(1'b0, 8'h00, 1'b1);

    // Overflow with tready low
    m_axis_tready = 1'b0;
    samples(80, 8'h00);
    chk("t4_level", 145'(fifo_level), 145'(4));
    chk("t4_overflow", 145'(overflow), 145'(1));
    m_axis_tready = 1'b1;
    idle(6);
    chk("t4_ovf_sticky", 145'(overflow), 145'(1));

    // Full FIFO with simultaneous pop and push
    do_reset();
    m_axis_tready = 1'b0;
    samples(64, 8'h80);
    samples(15, 8'h90);
    m_axis_tready = 1'b1;
    cycle(1'b1, 8'h9F, 1'b0);
    chk("t5_level", 145'(fifo_level), 145'(4));
    chk("t5_overflow", 145'(overflow), 145'(0));
    idle(6);

    // Reset mid-packet with buffered beats
    m_axis_tready = 1'b0;
    samples(39, 8'h20);
    do_reset();
    m_axis_tready = 1'b1;
    samples(16, 8'h10);
    chk("t6_tdata", 145'(m_axis_tdata), 145'(128'h1F1E1D1C1B1A19181716151413121110));
    chk("t6_tkeep", 145'(m_axis_tkeep), 145'(16'hFFFF));
    idle(2);

    chk("queue_drained", 145'(exp_q.size()), 145'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
